// File: rtl/adc_ctrl_pkg.sv
// +----------------------------------------------------------------------+
// | adc_ctrl_pkg: shared constants and types for the ADC capture slice    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package adc_ctrl_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DIV_W      = 8;
  localparam int DEF_CNT_W      = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef logic [DEF_DATA_W-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/adc_capture_ctrl_if.sv
// +----------------------------------------------------------------------+
// | adc_capture_ctrl_if: valid/ready sample stream toward the core        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface adc_capture_ctrl_if #(
  parameter int DATA_W = 8
) ();

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (output out_valid, output out_data, input out_ready);
  modport slave  (input out_valid, input out_data, output out_ready);

endinterface

`default_nettype wire

// File: rtl/adc_sample_fifo.sv
// +----------------------------------------------------------------------+
// | adc_sample_fifo: first-word-fall-through sample FIFO                  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_sample_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              i_push,
  input  wire logic [DATA_W-1:0] i_push_data,
  input  wire logic              i_pop,
  output logic      [DATA_W-1:0] o_pop_data,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              w_wr;
  logic              w_rd;

  // One extra pointer bit tells full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);

  assign w_rd = i_pop && !o_empty;
  assign w_wr = i_push && (!o_full || w_rd);

  assign o_pop_data = o_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + (ADDR_W+1)'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_push_data;
  end

endmodule

`default_nettype wire

// File: rtl/adc_capture_ctrl.sv
// +----------------------------------------------------------------------+
// | adc_capture_ctrl: ADC clock divider, burst capture and sample FIFO    |
// | Optional pair averaging: define ADC_CAPTURE_AVG_EN.  Rev 1.0          |
// +----------------------------------------------------------------------+
`default_nettype none

module adc_capture_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DIV_W      = DEF_DIV_W,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic [DIV_W-1:0]  cfg_div,
  input  wire logic [CNT_W-1:0]  cfg_burst_len,
  input  wire logic              start,
  input  wire logic              stop,
  output logic                   adc_clock,
  input  wire logic [DATA_W-1:0] adc_data,
  output logic                   busy,
  output logic                   overflow,
  input  wire logic              ovf_clear,
  adc_capture_ctrl_if.master     out_stream
);

  localparam logic [1:0] c_IDLE   = ST_IDLE;
  localparam logic [1:0] c_RUN    = ST_RUN;
  localparam logic [1:0] c_FINISH = ST_FINISH;

  logic [1:0]        r_state;
  logic [DIV_W-1:0]  r_div_lat;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [CNT_W-1:0]  r_len_lat;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_adc_clk;
  logic [DATA_W-1:0] r_cap_data;
  logic              r_cap_vld;
  logic              r_overflow;

  logic              w_tc;
  logic              w_capture;
  logic              w_sample_done;
  logic [DATA_W-1:0] w_sample;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_drop;

  // A stop overrides the divider, so no new capture starts in that cycle.
  assign w_tc      = (r_state == c_RUN) && !stop && (r_div_cnt == r_div_lat);
  assign w_capture = w_tc && r_adc_clk;
  assign w_cnt_nxt = r_cnt + CNT_W'(1);

`ifdef ADC_CAPTURE_AVG_EN
  logic              r_pair_vld;
  logic [DATA_W-1:0] r_pair_data;
  logic [DATA_W:0]   w_pair_sum;

  assign w_pair_sum    = {1'b0, r_pair_data} + {1'b0, adc_data};
  assign w_sample_done = w_capture && r_pair_vld;
  assign w_sample      = w_pair_sum[DATA_W:1];

  // Leaving RUN discards any unpaired sample.
  always_ff @(posedge clock) begin
    if (reset || (r_state != c_RUN)) begin
      r_pair_vld  <= 1'b0;
      r_pair_data <= '0;
    end else if (w_capture) begin
      r_pair_vld <= !r_pair_vld;
      if (!r_pair_vld) r_pair_data <= adc_data;
    end
  end
`else
  assign w_sample_done = w_capture;
  assign w_sample      = adc_data;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= c_IDLE;
      r_div_lat  <= '0;
      r_div_cnt  <= '0;
      r_len_lat  <= '0;
      r_cnt      <= '0;
      r_adc_clk  <= 1'b0;
      r_cap_data <= '0;
      r_cap_vld  <= 1'b0;
    end else begin
      r_cap_vld <= w_sample_done;
      if (w_sample_done) r_cap_data <= w_sample;
      case (r_state)
        c_IDLE: begin
          r_adc_clk <= 1'b0;
          if (start) begin
            r_div_lat <= cfg_div;
            r_len_lat <= cfg_burst_len;
            r_div_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= c_RUN;
          end
        end
        c_RUN: begin
          if (stop) begin
            r_adc_clk <= 1'b0;
            r_state   <= c_FINISH;
          end else begin
            if (w_tc) begin
              r_div_cnt <= '0;
              r_adc_clk <= !r_adc_clk;
            end else begin
              r_div_cnt <= r_div_cnt + DIV_W'(1);
            end
            if (w_sample_done) begin
              r_cnt <= w_cnt_nxt;
              if ((r_len_lat != '0) && (w_cnt_nxt == r_len_lat)) r_state <= c_FINISH;
            end
          end
        end
        c_FINISH: begin
          r_adc_clk <= 1'b0;
          r_state   <= c_IDLE;
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign w_pop  = out_stream.out_ready && !w_empty;
  assign w_drop = r_cap_vld && w_full && !w_pop;

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clock) begin
    if (reset)          r_overflow <= 1'b0;
    else if (w_drop)    r_overflow <= 1'b1;
    else if (ovf_clear) r_overflow <= 1'b0;
  end

  adc_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .i_push      (r_cap_vld),
    .i_push_data (r_cap_data),
    .i_pop       (w_pop),
    .o_pop_data  (out_stream.out_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign out_stream.out_valid = !w_empty;
  assign adc_clock            = r_adc_clk;
  assign busy                 = (r_state == c_RUN) || (r_state == c_FINISH);
  assign overflow             = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_adc_capture_ctrl.sv
// +----------------------------------------------------------------------+
// | tb_adc_capture_ctrl: randomized self-checking bench for the ADC ctrl  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_adc_capture_ctrl;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int AVG = 1;
`else
  localparam int AVG = 0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cfg_div = '0;
  logic [15:0] cfg_burst_len = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ovf_clear = 1'b0;
  logic [7:0]  adc_data = '0;
  logic        adc_clock;
  logic        busy;
  logic        overflow;

  adc_capture_ctrl_if #(.DATA_W(8)) u_if ();

  adc_capture_ctrl #(
    .DATA_W(8), .DIV_W(8), .CNT_W(16), .FIFO_DEPTH(8)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .cfg_div       (cfg_div),
    .cfg_burst_len (cfg_burst_len),
    .start         (start),
    .stop          (stop),
    .adc_clock     (adc_clock),
    .adc_data      (adc_data),
    .busy          (busy),
    .overflow      (overflow),
    .ovf_clear     (ovf_clear),
    .out_stream    (u_if.master)
  );

  always #5 clock = ~clock;

  int         n_checks = 0;
  int         n_fails  = 0;
  int         cyc = 0;
  logic       prev_clk = 1'b0;
  logic       prev_busy = 1'b0;
  int         busy_rise = -1;
  int         busy_fall = -1;
  int         first_valid = -1;
  int         rise_q[$];
  int         fall_q[$];
  logic [7:0] pres_q[$];
  logic [7:0] got_q[$];
  logic [7:0] stim_q[$];
  logic [7:0] ramp = '0;
  bit         use_ramp = 1'b0;
  int         pushes_done = 0;
  bit         pending_push = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Expected k-th output: the k-th presented sample, or the k-th pair average.
  function automatic logic [7:0] exp_out(input int k);
    logic [8:0] s;
    if (AVG == 0) return (k < pres_q.size()) ? pres_q[k] : 8'hxx;
    if (2*k+1 >= pres_q.size()) return 8'hxx;
    s = {1'b0, pres_q[2*k]} + {1'b0, pres_q[2*k+1]};
    return s[8:1];
  endfunction

  // One core cycle: record handshakes, ADC edges and busy edges; new ADC data on each rise.
  task automatic tick();
    if (u_if.out_valid && u_if.out_ready) got_q.push_back(u_if.out_data);
    pushes_done += int'(pending_push);
    pending_push = 1'b0;
    @(negedge clock);
    cyc++;
    if (adc_clock && !prev_clk) begin
      rise_q.push_back(cyc);
      if (stim_q.size() > 0) adc_data = stim_q.pop_front();
      else if (use_ramp) begin adc_data = ramp; ramp++; end
      else adc_data = 8'($urandom);
      pres_q.push_back(adc_data);
    end
    if (!adc_clock && prev_clk) begin
      fall_q.push_back(cyc);
      pending_push = (AVG == 0) || (fall_q.size() % 2 == 0);
    end
    if (busy && !prev_busy) busy_rise = cyc;
    if (!busy && prev_busy) busy_fall = cyc;
    if (u_if.out_valid && first_valid < 0) first_valid = cyc;
    prev_clk  = adc_clock;
    prev_busy = busy;
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; ovf_clear = 1'b0; u_if.out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    rise_q.delete(); fall_q.delete(); pres_q.delete(); got_q.delete(); stim_q.delete();
    busy_rise = -1; busy_fall = -1; first_valid = -1;
    pushes_done = 0; pending_push = 1'b0;
    prev_clk = adc_clock; prev_busy = busy;
  endtask

  task automatic start_run(input int div, input int len);
    cfg_div = 8'(div); cfg_burst_len = 16'(len); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input bit rand_ready);
    int k = 0;
    while (busy && k < 3000) begin
      if (rand_ready) u_if.out_ready = 1'($urandom_range(0, 1));
      tick(); k++;
    end
    if (busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain(input string tag, input int n);
    int k = 0;
    u_if.out_ready = 1'b1;
    while (got_q.size() < n && k < 400) begin tick(); k++; end
    repeat (6) tick();
    u_if.out_ready = 1'b0;
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk({tag, "_data"}, got_q[i], exp_out(i));
  endtask

  task automatic burst_test(input string tag, input int div, input int len,
                            input bit rand_ready, input bit poke);
    do_reset();
    start_run(div, len);
    if (poke) begin
      repeat (10) tick();
      cfg_div = 8'd7; cfg_burst_len = 16'd2; start = 1'b1;
      tick();
      start = 1'b0;
    end
    wait_idle(rand_ready);
    drain(tag, len);
    chk({tag, "_captures"}, fall_q.size(), (AVG != 0) ? 2*len : len);
    for (int i = 1; i < rise_q.size(); i++) chk({tag, "_period"}, rise_q[i] - rise_q[i-1], 2*(div+1));
    if (rise_q.size() > 0) chk({tag, "_first_rise"}, rise_q[0] - busy_rise, div + 1);
    if (fall_q.size() > AVG) begin
      chk({tag, "_busy_fall"}, busy_fall - fall_q[fall_q.size()-1], 1);
      chk({tag, "_valid_lat"}, first_valid - (fall_q[AVG] - 1), 2);
    end
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    int k;
    int n;

    do_reset();
    chk("rst_adc_clock", adc_clock, 0);
    chk("rst_valid", u_if.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", u_if.out_data, 0);

    // Basic ramp burst, then a start/config change while busy.
    use_ramp = 1'b1; ramp = 8'h10;
    burst_test("basic", 1, 4, 1'b0, 1'b0);
    ramp = 8'h40;
    burst_test("busy_poke", 2, 6, 1'b0, 1'b1);

    use_ramp = 1'b0;
    for (int r = 0; r < 6; r++)
      burst_test("rnd", $urandom_range(0, 4), (AVG != 0) ? $urandom_range(1, 4) : $urandom_range(1, 8),
                 1'b1, 1'b0);

    // Fixed sample table.
    do_reset();
    stim_q = '{8'h10, 8'h13, 8'hFF, 8'hFE};
    start_run(1, 2);
    wait_idle(1'b0);
    drain("table", 2);
    if (got_q.size() >= 2) begin
      chk("table_out0", got_q[0], (AVG != 0) ? 8'h11 : 8'h10);
      chk("table_out1", got_q[1], (AVG != 0) ? 8'hFE : 8'h13);
    end
    chk("table_idle", busy, 0);

    // Overflow with a stalled consumer.
    do_reset();
    use_ramp = 1'b1; ramp = 8'h00;
    start_run(0, 0);
    for (int i = 0; i < 60; i++) begin
      tick();
      chk("ovf_fill", overflow, (pushes_done > 8) ? 1 : 0);
    end
    k = 0;
    while (pending_push && k < 10) begin tick(); k++; end
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_clear", overflow, 0);
    k = 0;
    while (!pending_push && k < 10) begin tick(); k++; end
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_set_wins", overflow, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(1'b0);
    drain("ovf_keep", 8);
    ovf_clear = 1'b1; tick(); ovf_clear = 1'b0;
    chk("ovf_clear_idle", overflow, 0);

    // Full FIFO with a pop in the cycle the next sample lands.
    do_reset();
    ramp = 8'h80;
    start_run(3, 0);
    k = 0;
    while (!(pending_push && pushes_done == 8) && k < 400) begin tick(); k++; end
    chk("full_pre_ovf", overflow, 0);
    chk("full_valid", u_if.out_valid, 1);
    u_if.out_ready = 1'b1; tick(); u_if.out_ready = 1'b0;
    tick();
    chk("full_pop_ovf", overflow, 0);
    stop = 1'b1; tick(); stop = 1'b0;
    wait_idle(1'b0);
    drain("full_pop", 9);

    // Stop during the high phase of adc_clock.
    do_reset();
    ramp = 8'h20;
    start_run(3, 0);
    k = 0;
    while (!(rise_q.size() >= 4 && rise_q[rise_q.size()-1] == cyc) && k < 400) begin tick(); k++; end
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_clk_low", adc_clock, 0);
    chk("stop_finish", busy, 1);
    tick();
    chk("stop_idle", busy, 0);
    n = pres_q.size() - 1;
    drain("stop_drain", (AVG != 0) ? n / 2 : n);

    // Reset in the middle of a run flushes everything.
    do_reset();
    start_run(0, 0);
    repeat (12) tick();
    chk("mid_valid_pre", u_if.out_valid, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_clk", adc_clock, 0);
    chk("mid_rst_valid", u_if.out_valid, 0);
    chk("mid_rst_data", u_if.out_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
